// File: rtl/addsub_pkg.sv
// Shared encodings and helpers for the digit-serial add/subtract unit.
// Op encoding, FSM states and the digit-counter width function.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ADD_SAT = 2'b10,
        OP_SUB_SAT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Counter must hold 0..n-1; a single-digit operation still needs one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple of full adders.
// Exposes the carry into the MSB so the caller can form signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             c_msb,
    output logic             cout
);

    logic [DIGIT:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_msb = c[DIGIT-1];
    assign cout  = c[DIGIT];

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle add/subtract, DIGIT bits per cycle, LSB digit first, with
// optional signed saturation, raw carry-out and signed-overflow flags.
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             a_neg;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] d_sum;
    logic             d_cmsb;
    logic             d_cout;
    logic [WIDTH-1:0] res_next;
    logic             ovf_raw;
    logic             sat_mode;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a     (sa[DIGIT-1:0]),
        .b     (sb[DIGIT-1:0]),
        .cin   (carry),
        .s     (d_sum),
        .c_msb (d_cmsb),
        .cout  (d_cout)
    );

    // New digit enters at the MSB end; after N cycles the LSB digit has
    // reached bit 0 and the full result is aligned.
    assign res_next = (res >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));
    assign ovf_raw  = d_cmsb ^ d_cout;
    assign sat_mode = (op_q == OP_ADD_SAT) || (op_q == OP_SUB_SAT);

    // NOTE: shift registers are reset too, so a reset mid-operation leaves no stale digits behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            sa        <= '0;
            sb        <= '0;
            res       <= '0;
            carry     <= 1'b0;
            a_neg     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sa       <= a;
                        sb       <= op[0] ? ~b : b;
                        op_q     <= op_e'(op);
                        a_neg    <= a[WIDTH-1];
                        carry    <= op[0];
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    sa    <= sa >> DIGIT;
                    sb    <= sb >> DIGIT;
                    res   <= res_next;
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        // Final digit holds the MSB, so its carries give ovf.
                        sum       <= (sat_mode && ovf_raw) ? (a_neg ? SAT_MIN : SAT_MAX)
                                                           : res_next;
                        cout      <= d_cout;
                        ovf       <= ovf_raw;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench: directed vector table, DIGIT sweep, stall/ignore,
// mid-operation reset and random back-to-back traffic against a word-level model.
module tb_digit_serial_addsub;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, cout, ovf;
    logic [1:0]  op;
    logic [31:0] a, b, sum;

    logic        sv_in_valid, sv_out_ready;
    logic [1:0]  sv_op;
    logic [31:0] sv_a, sv_b;
    logic        d1_in_ready, d1_out_valid, d1_cout, d1_ovf;
    logic [31:0] d1_sum;
    logic        d32_in_ready, d32_out_valid, d32_cout, d32_ovf;
    logic [31:0] d32_sum;

    int passed = 0;
    int total  = 0;
    vec_t vecs[11];

    digit_serial_addsub #(.WIDTH(32), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    digit_serial_addsub #(.WIDTH(32), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv_in_valid), .in_ready(d1_in_ready),
        .op(sv_op), .a(sv_a), .b(sv_b), .out_valid(d1_out_valid), .out_ready(sv_out_ready),
        .sum(d1_sum), .cout(d1_cout), .ovf(d1_ovf)
    );

    digit_serial_addsub #(.WIDTH(32), .DIGIT(32)) dut_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv_in_valid), .in_ready(d32_in_ready),
        .op(sv_op), .a(sv_a), .b(sv_b), .out_valid(d32_out_valid), .out_ready(sv_out_ready),
        .sum(d32_sum), .cout(d32_cout), .ovf(d32_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] be;
        logic [32:0] full;
        exp_t e;
        be     = o[0] ? ~y : y;
        full   = {1'b0, x} + {1'b0, be} + 33'(o[0]);
        e.cout = full[32];
        e.ovf  = (x[31] == be[31]) && (full[31] != x[31]);
        e.sum  = (o[1] && e.ovf) ? (x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : full[31:0];
        return e;
    endfunction

    // Called just after a rising edge with the main DUT idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] s, output logic c, output logic v, output int lat);
        in_valid = 1'b1;
        op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum; c = cout; v = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic sweep(input int idx);
        int cyc, lat1, lat32;
        logic got1, got32;
        logic [31:0] s1, s32;
        logic c1, c32, v1, v32;
        sv_in_valid = 1'b1;
        sv_op = vecs[idx].op; sv_a = vecs[idx].a; sv_b = vecs[idx].b;
        @(posedge clk); #1;
        sv_in_valid = 1'b0;
        cyc = 0; got1 = 1'b0; got32 = 1'b0; lat1 = 0; lat32 = 0;
        s1 = '0; s32 = '0; c1 = 0; c32 = 0; v1 = 0; v32 = 0;
        while (!(got1 && got32) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (!got1 && d1_out_valid) begin
                got1 = 1'b1; lat1 = cyc; s1 = d1_sum; c1 = d1_cout; v1 = d1_ovf;
            end
            if (!got32 && d32_out_valid) begin
                got32 = 1'b1; lat32 = cyc; s32 = d32_sum; c32 = d32_cout; v32 = d32_ovf;
            end
        end
        check("sweep_d1_latency", lat1, 32);
        check("sweep_d32_latency", lat32, 1);
        check("sweep_d1_sum", s1, vecs[idx].sum);
        check("sweep_d32_sum", s32, vecs[idx].sum);
        check("sweep_d1_cout", 32'(c1), 32'(vecs[idx].cout));
        check("sweep_d32_cout", 32'(c32), 32'(vecs[idx].cout));
        check("sweep_d1_ovf", 32'(v1), 32'(vecs[idx].ovf));
        check("sweep_d32_ovf", 32'(v32), 32'(vecs[idx].ovf));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] s;
        logic c, v;
        int lat;
        logic seen;
        exp_t q[$];
        exp_t e;
        int accepted, results, cyc;
        logic acc, hs;

        vecs[0]  = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[1]  = '{2'b10, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[2]  = '{2'b01, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1};
        vecs[4]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5]  = '{2'b00, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1};
        vecs[7]  = '{2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[8]  = '{2'b01, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[9]  = '{2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
        sv_in_valid = 1'b0; sv_out_ready = 1'b1; sv_op = 2'b00; sv_a = '0; sv_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", sum, 32'd0);
        check("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table on the DIGIT=4 instance.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, s, c, v, lat);
            check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i), 32'(v), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_latency", i), lat, 8);
        end

        // Inputs pulsed during BUSY are ignored; result held through a 5-cycle stall.
        in_valid = 1'b1; op = 2'b00; a = 32'h10; b = 32'h20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stall_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_sum", sum, 32'h30);
            check("stall_flags_ready", {29'd0, cout, ovf, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("no_second_result", 32'(seen), 32'd0);

        // Asynchronous reset in BUSY cycle 3 (sum still holds 0x30).
        in_valid = 1'b1; op = 2'b00; a = 32'h5; b = 32'h6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_sum", sum, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_discards_result", 32'(seen), 32'd0);
        run_op(2'b00, 32'd3, 32'd4, s, c, v, lat);
        check("post_rst_sum", s, 32'd7);

        // DIGIT sweep: same vectors through DIGIT=1 and DIGIT=32 instances.
        sweep(0);
        sweep(4);
        sweep(7);

        // Random back-to-back traffic with consumer stalls.
        accepted = 0; results = 0; cyc = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        while (results < 24 && cyc < 3000) begin
            if (!in_valid && accepted < 24 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                op = 2'($urandom);
                a  = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 : $urandom;
                b  = ($urandom_range(0, 3) == 0) ? 32'h8000_0010 : $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rand_sum", sum, e.sum);
                    check("rand_cout", 32'(cout), 32'(e.cout));
                    check("rand_ovf", 32'(ovf), 32'(e.ovf));
                end
                results++;
            end
            if (acc) begin
                q.push_back(golden(op, a, b));
                accepted++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("rand_accepted", accepted, 24);
        check("rand_results", results, accepted);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised, multi-cycle successor to the combinational 32-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, carrying between cycles in a flop.
- Supports signed-saturating modes and reports carry-out and signed overflow.
- Sits between operand staging and writeback in the PIM arithmetic datapath. It trades latency for area, which makes it a bit-serial reference for synthesized PIM kernels.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be ≥2 and a multiple of DIGIT.
- DIGIT, 1, bits processed per BUSY cycle. Must be 1..WIDTH. N = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- op  input  2  00 ADD, 01 SUB, 10 ADD_SAT, 11 SUB_SAT
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result; saturated in *_SAT modes
- cout  output  1  raw carry-out of MSB; for SUB, 1 means no borrow
- ovf  output  1  two's-complement overflow of the unsaturated result

Behaviour:
- Reset is asynchronous, active-low. It is the only clock and reset of the block.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - sum = 0, cout = 0, ovf = 0
  - internal shift registers and carry = 0
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge k:
    - latch a into shift register SA.
    - latch b into shift register SB, inverted when op[0] = 1.
    - latch op.
    - set carry = op[0].
    - clear digit counter; go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0. in_valid and operands are ignored.
  - Each cycle:
    - one DIGIT-wide ripple add of SA[DIGIT-1:0] + SB[DIGIT-1:0] + carry.
    - result digit shifts into the MSB end of the result register; SA and SB shift right by DIGIT.
    - carry register takes the digit carry-out.
    - counter increments.
  - On the N-th BUSY cycle (counter == N-1), the result commits and state goes to DONE at edge k+N.
  - out_valid is therefore first high in the cycle after edge k+N. With DIGIT = WIDTH, latency is 1 BUSY cycle.
- Result commit, registered at the DONE transition:
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB, i.e. (sa_msb == sb_eff_msb) && (res_msb != sa_msb).
  - ADD and SUB: sum = raw result.
  - *_SAT with ovf = 1: sum = 0x7F..F if the original a was non-negative, else 0x80..0. Saturation depends only on the sign of a.
  - ovf is reported in all modes, even when saturation is applied.
- DONE:
  - out_valid = 1, in_ready = 0. sum, cout and ovf are held stable.
  - On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
  - No accept occurs in the same cycle as the result handshake. Minimum initiation interval is N+2 cycles.
- Wrap-around: all arithmetic is modulo 2^WIDTH. 0xFFFFFFFF + 1 gives sum 0, cout 1.
- Reset mid-operation, in BUSY or DONE: immediately returns all outputs to reset values. The partial result is discarded and no out_valid is produced.
- out_ready while out_valid = 0 has no effect. in_valid may stay high across the whole operation without causing a second accept until IDLE.

Decomposition:
- Package addsub_pkg:
  - op encodings OP_ADD, OP_SUB, OP_ADD_SAT, OP_SUB_SAT.
  - state encoding ST_IDLE, ST_BUSY, ST_DONE.
  - function computing the counter width, clog2(N) with a minimum of 1.
- Sub-module digit_adder #(DIGIT):
  - combinational DIGIT-bit ripple of full adders.
  - exposes the carry into its MSB so ovf can be formed on the final digit.
  - instantiated once.

Test Plan:
- WIDTH=32, DIGIT=4, ADD a=0x7FFFFFFF, b=1 -> out_valid first high 8 cycles after the accept edge; sum=0x80000000, cout=0, ovf=1. Same operands with ADD_SAT -> sum=0x7FFFFFFF, ovf=1.
- SUB a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0. SUB_SAT a=0x80000000, b=1 -> sum=0x80000000, ovf=1, cout=1.
- ADD a=0xFFFFFFFF, b=1 -> sum=0, cout=1, ovf=0. Sweep DIGIT ∈ {1,4,32} -> latency of 32, 8 and 1 BUSY cycles, identical results.
- Hold out_ready=0 for 5 cycles in DONE -> sum, cout and ovf stable, in_ready=0. Pulse in_valid with new operands during BUSY -> ignored, no second result.
- Assert rst_n=0 at BUSY cycle 3 -> out_valid=0, in_ready=1, sum=0 asynchronously. Next accepted ADD 3+4 -> sum=7.
- Randomised back-to-back traffic with random out_ready stalls, compared against a golden model -> every accepted request yields exactly one result, in order.
